clk_div_prog: RTL



---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_prog.sv | 112 +++++++++++
 2 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int CNT_W   = 16;
  localparam int DIV_MIN = 2;

  typedef logic [CNT_W-1:0] div_t;

  // First counter value of the high phase; the low phase is floor(N/2) cycles.
  function automatic div_t half_thresh(input div_t n);
    return n >> 1'b1;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a shadowed divisor that is
// applied only at period boundaries or on a synchronous re-phase.
module clk_div_prog #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_b,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic [CNT_W-1:0] div_act,
  output logic             clk_out,
  output logic             tick
);

  import clk_div_pkg::*;

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN_V = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_out_q, clk_out_d;
  logic             div_err_q, div_err_d;

  logic [CNT_W-1:0] last_s;
  logic [CNT_W-1:0] thresh_s;
  logic             boundary_s;
  logic             xfer_s;
  logic             div_ok_s;
  logic             load_s;
  logic             apply_s;

  assign last_s     = div_act_q - ONE_V;
  assign boundary_s = en & (cnt_q == last_s);
  assign xfer_s     = div_valid & ~pend_valid_q;
  assign div_ok_s   = (div_in >= DIV_MIN_V);
  assign load_s     = xfer_s & div_ok_s;
  // load_s needs an empty slot and apply_s a full one, so they never coincide.
  assign apply_s    = pend_valid_q & (sync_clr | boundary_s);

  always_comb begin
    cnt_d        = cnt_q;
    div_act_d    = div_act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    div_err_d    = 1'b0;

    if (sync_clr) begin
      cnt_d = '0;
    end else if (boundary_s) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + ONE_V;
    end else begin
      cnt_d = cnt_q;
    end

    if (apply_s) begin
      div_act_d    = pend_q;
      pend_valid_d = 1'b0;
    end else if (load_s) begin
      pend_d       = div_in;
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    div_err_d = xfer_s & ~div_ok_s;
  end

  if (CNT_W == $bits(div_t)) begin : g_pkg_half
    assign thresh_s = half_thresh(div_act_d);
  end else begin : g_shift_half
    assign thresh_s = div_act_d >> 1'b1;
  end

  // Registering a function of next-state keeps clk_out free of combinational paths.
  assign clk_out_d = (cnt_d >= thresh_s);

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q        <= '0;
      div_act_q    <= DEF_DIV_V;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_act_q    <= div_act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      div_err_q    <= div_err_d;
    end
  end

  assign div_ready = ~pend_valid_q;
  assign div_err   = div_err_q;
  assign div_act   = div_act_q;
  assign clk_out   = clk_out_q;
  assign tick      = boundary_s;

endmodule
